// File: rtl/matrix_serial_tx.sv
// Serial transmitter: start bit, WIDTH data bits LSB first, optional even parity, stop bit.
// One word is accepted per frame through a valid/ready handshake.
module matrix_serial_tx #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned BIT_CYCLES = 1,
    parameter bit          PARITY_EN  = 1'b1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             sout,
    output logic             busy,
    output logic             frame_done
);

    localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cyc_q, cyc_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             par_q, par_d;
    logic             bit_end;
    logic             sout_d;
    logic             frame_done_d;

    // State, datapath and registered outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            cyc_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            sout       <= 1'b1;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            sout       <= sout_d;
            tx_ready   <= (state_d == IDLE);
            busy       <= (state_d != IDLE);
            frame_done <= frame_done_d;
        end
    end

    // Next-state, counters and next output values
    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        par_d        = par_q;
        sout_d       = 1'b1;
        frame_done_d = 1'b0;
        bit_end      = (cyc_q == CYC_LAST);

        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    shift_d = tx_data;
                    par_d   = ^tx_data;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == BIT_LAST) begin
                        state_d = PARITY_EN ? PARITY : STOP;
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        shift_d = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Counters restart on every state change; cycle counter also restarts per data bit
        if (state_d != state_q) begin
            cyc_d = '0;
            bit_d = '0;
        end else if (state_q != IDLE) begin
            cyc_d = bit_end ? '0 : cyc_q + CW'(1);
        end

        case (state_d)
            START:   sout_d = 1'b0;
            DATA:    sout_d = shift_d[0];
            PARITY:  sout_d = par_d;
            default: sout_d = 1'b1;
        endcase

        frame_done_d = (state_d == STOP) && (cyc_d == CYC_LAST);
    end

endmodule

// File: tb/tb_matrix_serial_tx.sv
// Self-checking bench for matrix_serial_tx: two instances (fast with parity, slow without)
// compared cycle by cycle against a frame model built from the bit-level frame rules.
module tb_matrix_serial_tx;

    logic       CLK;
    logic       RST_N;
    logic [7:0] tx_data0, tx_data1;
    logic       tx_valid0, tx_valid1;
    logic       tx_ready0, tx_ready1;
    logic       sout0, sout1;
    logic       busy0, busy1;
    logic       fd0, fd1;

    int checks;
    int errors;
    bit exp_bits[$];

    logic obs_sout, obs_ready, obs_busy, obs_fd;

    matrix_serial_tx #(.WIDTH(8), .BIT_CYCLES(1), .PARITY_EN(1'b1)) u_dut0 (
        .CLK(CLK), .RST_N(RST_N), .tx_data(tx_data0), .tx_valid(tx_valid0),
        .tx_ready(tx_ready0), .sout(sout0), .busy(busy0), .frame_done(fd0)
    );

    matrix_serial_tx #(.WIDTH(8), .BIT_CYCLES(4), .PARITY_EN(1'b0)) u_dut1 (
        .CLK(CLK), .RST_N(RST_N), .tx_data(tx_data1), .tx_valid(tx_valid1),
        .tx_ready(tx_ready1), .sout(sout1), .busy(busy1), .frame_done(fd1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion earlier");
        $fatal(1, "watchdog");
    end

    // Expected serial waveform: each frame bit expanded to bc cycles
    task automatic build_frame(input logic [7:0] d, input int bc, input bit pen);
        int ones;
        bit seq[$];
        ones = 0;
        exp_bits.delete();
        seq.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            seq.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pen) seq.push_back(bit'(ones % 2));
        seq.push_back(1'b1);
        foreach (seq[i]) begin
            for (int c = 0; c < bc; c++) exp_bits.push_back(seq[i]);
        end
    endtask

    task automatic sample(input bit sel);
        if (sel) begin
            obs_sout = sout1; obs_ready = tx_ready1; obs_busy = busy1; obs_fd = fd1;
        end else begin
            obs_sout = sout0; obs_ready = tx_ready0; obs_busy = busy0; obs_fd = fd0;
        end
    endtask

    task automatic wait_ready(input bit sel, output bit ok);
        int n;
        n = 0;
        sample(sel);
        while (!obs_ready && n < 200) begin
            @(posedge CLK); #1;
            sample(sel);
            n++;
        end
        ok = obs_ready;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_ready dut%0d: tx_ready=%b, required 1 within 200 cycles", sel, obs_ready);
        end
    endtask

    // Send one word on the chosen instance and compare every cycle of the frame
    task automatic run_frame(input bit sel, input logic [7:0] d, input string name);
        int  bc, f;
        bit  pen, ok;
        bc  = sel ? 4 : 1;
        pen = sel ? 1'b0 : 1'b1;
        wait_ready(sel, ok);
        if (!ok) return;
        build_frame(d, bc, pen);
        f = exp_bits.size();
        if (sel) begin tx_data1 = d; tx_valid1 = 1'b1; end
        else begin tx_data0 = d; tx_valid0 = 1'b1; end
        @(posedge CLK); #1;
        if (sel) tx_valid1 = 1'b0; else tx_valid0 = 1'b0;
        for (int j = 1; j <= f; j++) begin
            if (sel) tx_data1 = 8'($urandom); else tx_data0 = 8'($urandom);
            sample(sel);
            checks += 4;
            if (obs_sout !== exp_bits[j-1]) begin
                errors++;
                $display("FAIL %s cycle %0d sout: got %b expected %b", name, j, obs_sout, exp_bits[j-1]);
            end
            if (obs_fd !== (j == f)) begin
                errors++;
                $display("FAIL %s cycle %0d frame_done: got %b expected %b", name, j, obs_fd, (j == f));
            end
            if (obs_busy !== 1'b1) begin
                errors++;
                $display("FAIL %s cycle %0d busy: got %b expected 1", name, j, obs_busy);
            end
            if (obs_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s cycle %0d tx_ready: got %b expected 0", name, j, obs_ready);
            end
            @(posedge CLK); #1;
        end
        sample(sel);
        checks += 4;
        if (obs_ready !== 1'b1 || obs_busy !== 1'b0 || obs_sout !== 1'b1 || obs_fd !== 1'b0) begin
            errors++;
            $display("FAIL %s after frame: ready/busy/sout/fd got %b%b%b%b expected 1010",
                     name, obs_ready, obs_busy, obs_sout, obs_fd);
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        tx_valid0 = 1'b0; tx_valid1 = 1'b0;
        tx_data0 = 8'h00; tx_data1 = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        for (int s = 0; s < 2; s++) begin
            sample(bit'(s));
            checks++;
            if (obs_sout !== 1'b1 || obs_ready !== 1'b1 || obs_busy !== 1'b0 || obs_fd !== 1'b0) begin
                errors++;
                $display("FAIL reset dut%0d: sout/ready/busy/fd got %b%b%b%b expected 1100",
                         s, obs_sout, obs_ready, obs_busy, obs_fd);
            end
        end
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_basic();
        run_frame(1'b0, 8'hA5, "basic_a5");
    endtask

    task automatic test_odd_parity();
        run_frame(1'b0, 8'h01, "odd_parity_01");
    endtask

    task automatic test_slow_bits();
        run_frame(1'b1, 8'hF0, "slow_f0");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) run_frame(1'b0, 8'($urandom), "random_fast");
        for (int i = 0; i < 2; i++) run_frame(1'b1, 8'($urandom), "random_slow");
    endtask

    // tx_valid held high with new data every cycle; model predicts accepts every F+1 cycles
    task automatic test_back_to_back();
        int p;
        bit exp_sout;
        p = 0;
        tx_valid0 = 1'b1;
        for (int t = 0; t < 48; t++) begin
            sample(1'b0);
            exp_sout = (p == 0) ? 1'b1 : exp_bits[p-1];
            checks += 3;
            if (obs_ready !== (p == 0)) begin
                errors++;
                $display("FAIL b2b t=%0d tx_ready: got %b expected %b", t, obs_ready, (p == 0));
            end
            if (obs_sout !== exp_sout) begin
                errors++;
                $display("FAIL b2b t=%0d sout: got %b expected %b", t, obs_sout, exp_sout);
            end
            if (obs_fd !== (p == 11)) begin
                errors++;
                $display("FAIL b2b t=%0d frame_done: got %b expected %b", t, obs_fd, (p == 11));
            end
            tx_data0 = 8'($urandom);
            if (p == 0) begin
                build_frame(tx_data0, 1, 1'b1);
                p = 1;
            end else begin
                p = (p == 11) ? 0 : p + 1;
            end
            @(posedge CLK); #1;
        end
        tx_valid0 = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        wait_ready(1'b0, ok);
        if (!ok) return;
        tx_data0 = 8'hA5; tx_valid0 = 1'b1;
        @(posedge CLK); #1;
        tx_valid0 = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        checks++;
        if (sout0 !== 1'b0 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL midreset pre: sout/busy got %b%b expected 01", sout0, busy0);
        end
        #2;
        RST_N = 1'b0;
        #1;
        checks++;
        if (sout0 !== 1'b1 || tx_ready0 !== 1'b1 || busy0 !== 1'b0 || fd0 !== 1'b0) begin
            errors++;
            $display("FAIL midreset async: sout/ready/busy/fd got %b%b%b%b expected 1100",
                     sout0, tx_ready0, busy0, fd0);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK); #1;
            checks++;
            if (sout0 !== 1'b1 || tx_ready0 !== 1'b1 || busy0 !== 1'b0) begin
                errors++;
                $display("FAIL midreset residual cycle %0d: sout/ready/busy got %b%b%b expected 110",
                         i, sout0, tx_ready0, busy0);
            end
        end
        run_frame(1'b0, 8'h3C, "after_reset_3c");
    endtask

    task automatic test_idle();
        tx_valid0 = 1'b0; tx_valid1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tx_data0 = 8'($urandom); tx_data1 = 8'($urandom);
            @(posedge CLK); #1;
            checks += 2;
            if (sout0 !== 1'b1 || fd0 !== 1'b0 || tx_ready0 !== 1'b1) begin
                errors++;
                $display("FAIL idle0 cycle %0d: sout/fd/ready got %b%b%b expected 101", i, sout0, fd0, tx_ready0);
            end
            if (sout1 !== 1'b1 || fd1 !== 1'b0 || tx_ready1 !== 1'b1) begin
                errors++;
                $display("FAIL idle1 cycle %0d: sout/fd/ready got %b%b%b expected 101", i, sout1, fd1, tx_ready1);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_idle();
        test_basic();
        test_odd_parity();
        test_slow_bits();
        test_random();
        test_back_to_back();
        test_reset_mid_frame();
        test_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
